onehot_stream_monitor: RTL
==========================

// Module: onehot_stream_monitor
// PURPOSE
//  Clocked consumer of one-hot encoded vectors (decoder outputs, shift-one-hot selects, grant buses).
//  Registers each valid sample and classifies it as zero, one-hot or multi-hot, matching $onehot/$onehot0 semantics.
//  Encodes the set-bit index, counts violations with saturation, and captures the first offending vector.
//  Sits directly downstream of any one-hot producer; the violation outputs feed the cosim scoreboard.
// PARAMETERS
//  WIDTH       8   width of monitored vector, >=1
//  CNTW        16  width of saturating violation counter, >=1
//  ALLOW_ZERO  0   1: all-zero is legal ($onehot0 rule); 0: all-zero is a violation ($onehot rule)
//  IDXW        $clog2(WIDTH>1?WIDTH:2)   derived localparam, index width
//  POPW        $clog2(WIDTH+1)           derived localparam, popcount width
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous reset, active-low
//  in_valid      in   1      in_vec is sampled this cycle
//  in_vec        in   WIDTH  vector under check
//  clear         in   1      synchronous clear of err_cnt, sticky state and capture
//  chk_valid     out  1      registered: classification outputs valid
//  chk_onehot    out  1      popcount == 1
//  chk_zero      out  1      popcount == 0
//  chk_multi     out  1      popcount >= 2
//  chk_idx       out  IDXW   index of the set bit when chk_onehot, else 0
//  chk_pop       out  POPW   popcount of sample
//  err_cnt       out  CNTW   saturating count of violating samples
//  err_sticky    out  1      at least one violation since reset/clear
//  first_err_vec out  WIDTH  first violating vector since reset/clear
// BEHAVIOUR
//  - Reset (rst_n=0, async): every output 0; capture FSM -> ARMED.
//  - Latency 1: sample at edge N with in_valid=1 -> chk_* valid after edge N, chk_valid=1 for exactly that cycle.
//  - in_valid=0: chk_valid=0 next cycle; chk_onehot/zero/multi/idx/pop hold their last values.
//  - Exactly one of chk_onehot/chk_zero/chk_multi is 1 whenever chk_valid=1.
//  - Violation = chk_multi | (chk_zero & !ALLOW_ZERO); evaluated on the registered sample.
//  - err_cnt increments by 1 per violating sample on the edge after it is classified (visible 2 cycles after input).
//    It saturates at 2^CNTW-1 and never wraps.
//  - Capture FSM, two states:
//      ARMED  -> FAILED on first violation; first_err_vec <= sample and err_sticky <= 1 on the same edge as the first err_cnt update.
//      FAILED -> ARMED only on clear; later violations never overwrite first_err_vec.
//  - clear: on its edge err_cnt<=0, err_sticky<=0, first_err_vec<=0, FSM->ARMED.
//    clear has priority: a violation completing the counting stage on the clear edge is dropped.
//    An input sampled on the clear edge is classified and counted normally.
//    chk_* outputs are unaffected by clear.
//  - Back-to-back valid samples at full rate; no backpressure, no stall.
//  - WIDTH=1: chk_idx is 0 always; in_vec=1 -> onehot, 0 -> zero.
//  - Reset mid-stream: in-flight sample discarded; no partial count update.
//  - chk_idx for multi-hot or zero is 0 (not lowest set bit).
// STRUCTURE
//  - Package onehot_mon_pkg: typedef enum logic {MON_ARMED, MON_FAILED} mon_state_e;
//    function for the saturating increment.
//  - Sub-module onehot_popcount #(WIDTH): combinational popcount + index encode (pop, idx).
//    Instanced once on the input side; the result is registered.
//  - Top: stage-1 registers (valid, class, idx, pop, vec), stage-2 counter/sticky/capture FSM.
// TESTING
//  1 WIDTH=8, ALLOW_ZERO=0
//      in_vec=8'h10, valid -> next cycle chk_onehot=1, chk_idx=4, chk_pop=1, err_cnt stays 0
//  2 in_vec=8'h00 then 8'h81 back-to-back
//      -> chk_zero then chk_multi(pop=2); err_cnt=2; first_err_vec=8'h00; err_sticky=1
//  3 ALLOW_ZERO=1, in_vec=8'h00
//      -> chk_zero=1, err_cnt=0, err_sticky=0
//  4 CNTW=2, five multi-hot samples 8'h03
//      -> err_cnt 1,2,3,3,3 (saturates at 3, no wrap)
//  5 clear asserted on the same edge a violation would count
//      -> err_cnt=0, err_sticky=0, FSM ARMED
//      then in_vec=8'hF0 -> first_err_vec=8'hF0
//  6 rst_n pulsed low mid-stream, asynchronously between edges
//      -> all outputs 0 immediately; next sample 8'h01 -> chk_idx=0, chk_onehot=1

Source files
------------

// File: rtl/onehot_mon_pkg.sv
// rtl/onehot_mon_pkg.sv - shared types and helpers for the one-hot stream monitor
//   mon_state_e : capture FSM states
//   sat_inc     : saturating increment, caller supplies the ceiling

package onehot_mon_pkg;

    typedef enum logic {
        MON_ARMED  = 1'b0,
        MON_FAILED = 1'b1
    } mon_state_e;

    // Operates on a 64-bit container so one function serves any counter
    // width up to 64; the caller truncates the result back to its width.
    function automatic logic [63:0] sat_inc(input logic [63:0] cnt,
                                            input logic [63:0] max_val);
        return (cnt >= max_val) ? cnt : cnt + 64'd1;
    endfunction

endpackage

// File: rtl/onehot_popcount.sv
// rtl/onehot_popcount.sv - combinational popcount and one-hot index encoder
//   vec : vector under test
//   pop : number of set bits
//   idx : position of the set bit when pop == 1, otherwise 0

module onehot_popcount #(
    parameter  int WIDTH = 8,
    localparam int IDXW  = $clog2(WIDTH > 1 ? WIDTH : 2),
    localparam int POPW  = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [POPW-1:0]  pop,
    output logic [IDXW-1:0]  idx
);

    logic [IDXW-1:0] idx_or;

    // OR-ing the indices of all set bits is exact whenever only one bit is
    // set; for zero or multi-hot vectors the result is discarded below.
    always_comb begin
        pop    = '0;
        idx_or = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                pop    = pop + POPW'(1);
                idx_or = idx_or | IDXW'(i);
            end
        end
        idx = (pop == POPW'(1)) ? idx_or : '0;
    end

endmodule

// File: rtl/onehot_stream_monitor.sv
// rtl/onehot_stream_monitor.sv - registered one-hot classifier with violation counter and first-error capture
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_vec    : sample input, one sample per cycle, no backpressure
//   clear               : synchronous clear of err_cnt, sticky state and capture
//   chk_*               : stage-1 classification of the last valid sample
//   err_cnt             : saturating count of violating samples
//   err_sticky          : a violation has occurred since reset/clear
//   first_err_vec       : first violating vector since reset/clear

module onehot_stream_monitor
    import onehot_mon_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int CNTW       = 16,
    parameter  int ALLOW_ZERO = 0,
    localparam int IDXW       = $clog2(WIDTH > 1 ? WIDTH : 2),
    localparam int POPW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             clear,
    output logic             chk_valid,
    output logic             chk_onehot,
    output logic             chk_zero,
    output logic             chk_multi,
    output logic [IDXW-1:0]  chk_idx,
    output logic [POPW-1:0]  chk_pop,
    output logic [CNTW-1:0]  err_cnt,
    output logic             err_sticky,
    output logic [WIDTH-1:0] first_err_vec
);

    localparam logic [63:0] CNT_MAX     = (CNTW >= 64) ? '1 : ((64'd1 << CNTW) - 64'd1);
    localparam bit          ZERO_IS_ERR = (ALLOW_ZERO == 0);

    logic [POPW-1:0]  pop;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] vec_q;
    logic             viol;
    logic             capture;
    mon_state_e       state, state_next;

    onehot_popcount #(.WIDTH(WIDTH)) u_popcount (
        .vec (in_vec),
        .pop (pop),
        .idx (idx)
    );

    // Stage 1: classification registers hold their value while in_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid  <= 1'b0;
            chk_onehot <= 1'b0;
            chk_zero   <= 1'b0;
            chk_multi  <= 1'b0;
            chk_idx    <= '0;
            chk_pop    <= '0;
            vec_q      <= '0;
        end else begin
            chk_valid <= in_valid;
            if (in_valid) begin
                chk_onehot <= (pop == POPW'(1));
                chk_zero   <= (pop == '0);
                chk_multi  <= (pop > POPW'(1));
                chk_idx    <= idx;
                chk_pop    <= pop;
                vec_q      <= in_vec;
            end
        end
    end

    assign viol = chk_valid & (chk_multi | (chk_zero & ZERO_IS_ERR));

    // Stage 2: capture FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MON_ARMED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        if (clear) begin
            state_next = MON_ARMED;
        end else if (viol && state == MON_ARMED) begin
            state_next = MON_FAILED;
            capture    = 1'b1;
        end
    end

    // Stage 2: counter and capture register; clear wins over a completing violation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt       <= '0;
            first_err_vec <= '0;
        end else if (clear) begin
            err_cnt       <= '0;
            first_err_vec <= '0;
        end else begin
            if (viol) begin
                err_cnt <= CNTW'(sat_inc(64'(err_cnt), CNT_MAX));
            end
            if (capture) begin
                first_err_vec <= vec_q;
            end
        end
    end

    // Sticky flag is exactly "a first error has been captured".
    assign err_sticky = (state == MON_FAILED);

endmodule
